// File: rtl/inv_share_arbiter.sv
// inv_share_arbiter
// Two requesters share one conditional inverter (out = inv ? ~data : data).
// Requesters are picked round-robin and the result goes into a single output
// register with a valid/ready handshake. That register can take a new word
// in the same edge it hands off the old one, so a steady stream runs at one
// word per cycle.
// Optional feature: define INV_ARB_STATS_EN to add saturating per-requester
// grant counters and a synchronous clear input (stats_clr).
//
// state | meaning
// EMPTY | output register holds no word; out_valid = 0
// FULL  | output register holds a word for the consumer; out_valid = 1

module inv_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_inv,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             busy
`ifdef INV_ARB_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             last_grant;
  logic             grant_any;
  logic             grant_sel;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_inv;

  // Round-robin grant, handshake decode and next-state logic
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else if (req1_valid) begin
      grant_sel = 1'b1;
    end
    slot_free = (state == EMPTY) || out_ready;
    // Gating with rst_n keeps both readies low for every cycle that reset is held
    accept     = rst_n && slot_free && grant_any;
    req0_ready = accept && !grant_sel;
    req1_ready = accept && grant_sel;
    sel_data   = grant_sel ? req1_data : req0_data;
    sel_inv    = grant_sel ? req1_inv : req0_inv;
    state_nx   = state;
    if (accept) begin
      state_nx = FULL;
    end else if ((state == FULL) && out_ready) begin
      state_nx = EMPTY;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Result register and round-robin pointer; both load only on an accepted word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      out_data   <= sel_inv ? ~sel_data : sel_data;
      out_src    <= grant_sel;
      last_grant <= grant_sel;
    end
  end

  assign out_valid = (state == FULL);
  assign busy      = (state == FULL);

`ifdef INV_ARB_STATS_EN
  // Saturating grant counters; a clear takes priority over a grant in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && (grant_cnt0 != {CNT_W{1'b1}})) begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end
      if (req1_ready && (grant_cnt1 != {CNT_W{1'b1}})) begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_inv_share_arbiter.sv
// Testbench for inv_share_arbiter.
// Build with +define+INV_ARB_STATS_EN to include the grant counter test.
module tb_inv_share_arbiter;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_inv;
  logic [WIDTH-1:0] req0_data;
  logic             req1_valid, req1_ready, req1_inv;
  logic [WIDTH-1:0] req1_data;
  logic             out_valid, out_ready, out_src, busy;
  logic [WIDTH-1:0] out_data;
`ifdef INV_ARB_STATS_EN
  logic             stats_clr;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {src, data}
  logic [WIDTH:0] sb[$];
  logic           m_full;
  logic           m_last;

  inv_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_inv(req0_inv),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_inv(req1_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .busy(busy)
`ifdef INV_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Reference model and scoreboard, evaluated on the falling edge for the coming rising edge
  always @(negedge clk) begin
    logic          slot, g_any, g, e0, e1;
    logic [WIDTH:0] e;
    if (!rst_n) begin
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL mon_ready_in_reset: got %b%b, want 00", req0_ready, req1_ready);
      end
      m_full = 1'b0;
      m_last = 1'b1;
      sb.delete();
    end else begin
      slot  = !m_full || out_ready;
      g_any = req0_valid || req1_valid;
      g     = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e0    = slot && g_any && !g;
      e1    = slot && g_any && g;
      n_checks++;
      if (req0_ready !== e0 || req1_ready !== e1) begin
        n_fail++;
        $display("FAIL mon_ready: got %b%b, want %b%b", req0_ready, req1_ready, e0, e1);
      end
      n_checks++;
      if (out_valid !== m_full || busy !== m_full) begin
        n_fail++;
        $display("FAIL mon_out_valid: out_valid=%b busy=%b, want %b", out_valid, busy, m_full);
      end
      if (m_full && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL mon_sb_empty: out_data=%h with no word expected", out_data);
        end else begin
          e = sb.pop_front();
          if ({out_src, out_data} !== e) begin
            n_fail++;
            $display("FAIL mon_result: src/data=%b/%h, want %b/%h", out_src, out_data, e[WIDTH], e[WIDTH-1:0]);
          end
        end
      end
      if (e0 || e1) begin
        if (g) sb.push_back({1'b1, req1_inv ? ~req1_data : req1_data});
        else   sb.push_back({1'b0, req0_inv ? ~req0_data : req0_data});
        m_last = g;
        m_full = 1'b1;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = '0; req0_inv = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_inv = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // rst_n already low from time 0 with both requesters valid
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ready: got %b%b, want 00", req0_ready, req1_ready);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b data=%h src=%b busy=%b, want 0 00 0 0",
               out_valid, out_data, out_src, busy);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h5A; req0_inv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: got %b, want 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_inv = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 1'b0) begin
      n_fail++;
      $display("FAIL single_plain: valid=%b data=%h src=%b, want 1 5a 0", out_valid, out_data, out_src);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 1'b0) begin
      n_fail++;
      $display("FAIL single_inv: valid=%b data=%h src=%b, want 1 a5 0", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_alternate();
    logic [WIDTH-1:0] exp_d[4];
    logic             exp_s[4];
    exp_d = '{8'hF0, 8'h33, 8'hF0, 8'h33};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h0F; req0_inv = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h33; req1_inv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL alt_first_grant: got %b%b, want 10", req0_ready, req1_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_src !== exp_s[i]) begin
        n_fail++;
        $display("FAIL alt_seq[%0d]: valid=%b data=%h src=%b, want 1 %h %b",
                 i, out_valid, out_data, out_src, exp_d[i], exp_s[i]);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    req1_valid = 1'b1; req1_data = 8'hC3; req1_inv = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h11; req0_inv = 1'b0;
    req1_valid = 1'b1; req1_data = 8'h22; req1_inv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hC3 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b%b, want 1 c3 00",
                 i, out_valid, out_data, req0_ready, req1_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || out_data !== 8'hC3) begin
      n_fail++;
      $display("FAIL bp_release: ready=%b%b data=%h, want 10 c3", req0_ready, req1_ready, out_data);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || out_src !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next: valid=%b data=%h src=%b, want 1 11 0", out_valid, out_data, out_src);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h44; req0_inv = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_data = 8'h02;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ready: got %b%b, want 00", req0_ready, req1_ready);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_valid: got %b, want 0", out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    req0_data = 8'h01;
    @(negedge clk);
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_tie: got %b%b, want 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (out_data !== 8'h01 || out_src !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_result: data=%h src=%b, want 01 0", out_data, out_src);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1));
      req0_data  = 8'($urandom);
      req0_inv   = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req1_data  = 8'($urandom);
      req1_inv   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: %0d words left, want 0", sb.size());
    end
  endtask

`ifdef INV_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    stats_clr = 1'b0;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_inv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      req0_data = 8'(i);
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (grant_cnt0 !== 8'hFF || grant_cnt1 !== 8'h00) begin
      n_fail++;
      $display("FAIL stats_sat: cnt0=%h cnt1=%h, want ff 00", grant_cnt0, grant_cnt1);
    end
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    stats_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant_cnt0 !== 8'h00) begin
      n_fail++;
      $display("FAIL stats_clr: cnt0=%h, want 00", grant_cnt0);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (grant_cnt0 !== 8'h01 || grant_cnt1 !== 8'h00) begin
      n_fail++;
      $display("FAIL stats_after_clr: cnt0=%h cnt1=%h, want 01 00", grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
`ifdef INV_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    m_full = 1'b0;
    m_last = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef INV_ARB_STATS_EN
    test_stats();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/inv_share_arbiter.md
Name: inv_share_arbiter

Overview:
- Shares one conditional-inverter datapath (out = inv ? ~data : data) between two requesters.
- Round-robin arbitration with valid/ready handshakes on both requester ports and on the output port.
- Registered output stage, one result per cycle sustained throughput, holds the result under backpressure.
- Sits between two producers and a single downstream consumer of the inverter result.

Parameters:
- WIDTH, 8, data width of requests and result
- CNT_W, 8, width of the grant statistics counters (used only with the optional feature)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has a word
- req0_ready  output  1  requester 0 word accepted this cycle
- req0_data  input  WIDTH  requester 0 data
- req0_inv  input  1  requester 0 invert select
- req1_valid  input  1  requester 1 has a word
- req1_ready  output  1  requester 1 word accepted this cycle
- req1_data  input  WIDTH  requester 1 data
- req1_inv  input  1  requester 1 invert select
- out_valid  output  1  result register holds a valid word
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  registered result
- out_src  output  1  source of the result (0 = req0, 1 = req1)
- busy  output  1  equals out_valid

Behaviour:
- Reset is sampled only on a clk edge with rst_n=0.
- Reset values: out_valid=0, out_data=0, out_src=0, last_grant pointer=1 (req0 wins the first tie), stats counters=0.
- Two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- slot_free = (state==EMPTY) || out_ready.
- Grant is combinational:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - None valid: no grant.
- reqN_ready = slot_free && grant==N && reqN_valid. At most one ready is high per cycle; ready is 0 during reset.
- On an accepted request at edge E:
  - out_data <= inv ? ~data : data.
  - out_src <= N.
  - last_grant <= N.
  - State FULL.
  - Latency: result visible the cycle after acceptance.
- FULL && out_ready && no grant: state EMPTY at the next edge. out_data and out_src keep their last value.
- FULL && out_ready && grant: the register reloads in the same edge. State stays FULL, giving full throughput.
- FULL && !out_ready: out_data and out_src stay stable, both readies are 0, last_grant is unchanged.
- Requesters hold valid and data until ready. A valid dropped before ready is legal: nothing is captured, and last_grant is unchanged.
- Arbitration decisions do not depend on reqN_inv or reqN_data.
- Reset mid-operation:
  - Any pending result is discarded; out_valid=0 the next cycle.
  - last_grant returns to 1.
  - No ready is asserted while rst_n=0.

Optional Feature:
- Macro: INV_ARB_STATS_EN.
- Defined:
  - Adds input stats_clr (1 bit) and outputs grant_cnt0 and grant_cnt1 (CNT_W each).
  - Each counter increments on every accepted handshake of its requester.
  - Counters saturate at all-ones.
  - stats_clr=1 zeroes both counters at the next edge. Clear wins over a simultaneous grant, so the result is 0.
  - Counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- rst_n=0 for 2 cycles with both valids high -> req0_ready=req1_ready=0 during reset; afterwards out_valid=0, out_data=0x00, out_src=0, busy=0.
- Only req0 valid, data=0x5A, inv=0, out_ready=1 -> cycle after accept: out_data=0x5A, out_src=0. Next word 0x5A with inv=1 -> out_data=0xA5.
- Both valid continuously, out_ready=1, req0 data=0x0F inv=1, req1 data=0x33 inv=0 -> grants alternate 0,1,0,1 starting with req0. Outputs are 0xF0, 0x33, 0xF0, 0x33 on consecutive cycles, with no bubbles.
- Output FULL with 0xC3, out_ready=0 for 3 cycles, both requesters valid -> out_data stays 0xC3 and both readies stay 0. On release, the next word appears the following cycle, from the requester not last granted.
- Reset asserted while FULL with out_ready=0 -> out_valid=0 after that edge. After release, a tie grants req0 first.
- INV_ARB_STATS_EN with CNT_W=8: 300 req0 transfers -> grant_cnt0=255 and grant_cnt1=0. stats_clr asserted together with a req0 grant -> grant_cnt0=0 the next cycle.
